// File: rtl/imem_program_loader.sv
// Program loader: framed byte stream -> 32-bit big-endian words written into instruction memory.
// Latency: a word's write strobe is registered and appears one cycle after its fourth byte; done follows the checksum byte by one cycle.
// Backpressure: byte_ready depends only on state (one byte per cycle while loading) and is low outside LEN_HI/LEN_LO/DATA/CHECK.
module imem_program_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  // Largest legal word count: exactly fills the memory.
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  logic [2:0]            state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH:0]   word_addr_q, word_addr_d;  // one extra bit so a full memory does not wrap
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           shift_q, shift_d;          // first three bytes of the word in flight
  logic [7:0]            xor_q, xor_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;

  logic        xfer;
  logic [16:0] len_lo_n;
  logic [16:0] words_next;

  assign byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CHECK);
  assign xfer       = byte_valid & byte_ready;
  assign len_lo_n   = {1'b0, len_q[15:8], byte_in};
  assign words_next = 17'(word_addr_q) + 17'd1;

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERROR);
  assign cpu_reset  = (state_q != S_DONE);

  // Next-state logic: frame parsing, word assembly, running checksum and write generation.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_addr_d = word_addr_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    xor_d       = xor_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d     = S_LEN_HI;
          word_addr_d = '0;
          byte_cnt_d  = '0;
          xor_d       = '0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = byte_in;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = byte_in;
          if (len_lo_n == 17'd0)          state_d = S_CHECK;
          else if (len_lo_n > MAX_WORDS)  state_d = S_ERROR;
          else                            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          xor_d      = xor_q ^ byte_in;
          shift_d    = {shift_q[15:0], byte_in};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d        = 1'b1;
            addr_d      = word_addr_q[ADDR_WIDTH-1:0];
            wdata_d     = {shift_q, byte_in};
            word_addr_d = word_addr_q + 1'b1;
            // Leave DATA on the same edge that registers the final write.
            if (words_next == {1'b0, len_q}) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (xfer) state_d = (byte_in == xor_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any frame but leaves memory untouched.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      word_addr_q <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      xor_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_addr_q <= word_addr_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      xor_q       <= xor_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

endmodule
